// File: rtl/sync_debounce_pkg.sv
// Shared constants and helpers for the multi-channel synchroniser/debouncer.
// The optional glitch counter is enabled with the GLITCH_COUNTER_EN macro.
package sync_debounce_pkg;

   localparam int GLITCH_CNT_W = 8;
   localparam logic [GLITCH_CNT_W-1:0] GLITCH_CNT_MAX = 8'hFF;

   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_debounce_channel.sv
// One input line: flop-chain synchroniser, stability counter, edge strobes.
// Saturating glitch counter present only when GLITCH_COUNTER_EN is defined.
module sync_debounce_channel
   import sync_debounce_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int RESET_LEVEL     = 1
) (
   input  logic                    control_clock,
   input  logic                    reset,
   input  logic                    raw,
   input  logic                    glitch_clear,
   output logic                    level,
   output logic                    rise,
   output logic                    fall,
   output logic [GLITCH_CNT_W-1:0] glitch_count
);

   localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic RL = 1'(RESET_LEVEL);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_out;
   logic [CNT_W-1:0]       cnt;

   assign sync_out = sync_q[SYNC_STAGES-1];

   always_ff @(posedge control_clock) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{RL}};
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      end
   end

   // Any cycle agreeing with the current level restarts the stability run.
   always_ff @(posedge control_clock) begin
      if (reset) begin
         level <= RL;
         cnt   <= '0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         rise <= 1'b0;
         fall <= 1'b0;
         if (sync_out == level) begin
            cnt <= '0;
         end else if (cnt == CNT_MAX) begin
            level <= sync_out;
            cnt   <= '0;
            rise  <= sync_out;
            fall  <= ~sync_out;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

`ifdef GLITCH_COUNTER_EN
   logic [GLITCH_CNT_W-1:0] glitch_q;

   always_ff @(posedge control_clock) begin
      if (reset || glitch_clear) begin
         glitch_q <= '0;
      end else if ((sync_out == level) && (cnt != '0) && (glitch_q != GLITCH_CNT_MAX)) begin
         glitch_q <= glitch_q + 1'b1;
      end
   end

   assign glitch_count = glitch_q;
`else
   logic unused_glitch_clear;

   assign unused_glitch_clear = glitch_clear;
   assign glitch_count        = '0;
`endif

endmodule

// File: rtl/multi_channel_sync_debounce.sv
// CHANNELS independent pad inputs brought into control_clock, debounced, with edge strobes.
// Per-channel glitch counters exist only when GLITCH_COUNTER_EN is defined.
module multi_channel_sync_debounce
   import sync_debounce_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 8,
   parameter int RESET_LEVEL     = 1
) (
   input  logic                             control_clock,
   input  logic                             reset,
   input  logic [CHANNELS-1:0]              input_data,
   output logic [CHANNELS-1:0]              output_data,
   output logic [CHANNELS-1:0]              rise_pulse,
   output logic [CHANNELS-1:0]              fall_pulse,
   input  logic                             glitch_clear,
   output logic [GLITCH_CNT_W*CHANNELS-1:0] glitch_count
);

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      sync_debounce_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (RESET_LEVEL)
      ) u_ch (
         .control_clock (control_clock),
         .reset         (reset),
         .raw           (input_data[i]),
         .glitch_clear  (glitch_clear),
         .level         (output_data[i]),
         .rise          (rise_pulse[i]),
         .fall          (fall_pulse[i]),
         .glitch_count  (glitch_count[GLITCH_CNT_W*i +: GLITCH_CNT_W])
      );
   end

endmodule

// File: tb/tb_multi_channel_sync_debounce.sv
// Bench for multi_channel_sync_debounce: default build (2ch,S2,D8) and a 4ch,S3,D1 build,
// compared each cycle against a run-length reference model; honours GLITCH_COUNTER_EN.
module tb_multi_channel_sync_debounce;

`ifdef GLITCH_COUNTER_EN
   localparam bit GEN = 1'b1;
`else
   localparam bit GEN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic [1:0]  in_a, out_a, rise_a, fall_a;
   logic [15:0] gc_a;
   logic [3:0]  in_b, out_b, rise_b, fall_b;
   logic [31:0] gc_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   multi_channel_sync_debounce dut_a (
      .control_clock (clk),
      .reset         (rst),
      .input_data    (in_a),
      .output_data   (out_a),
      .rise_pulse    (rise_a),
      .fall_pulse    (fall_a),
      .glitch_clear  (clr),
      .glitch_count  (gc_a)
   );

   multi_channel_sync_debounce #(
      .CHANNELS        (4),
      .SYNC_STAGES     (3),
      .DEBOUNCE_CYCLES (1),
      .RESET_LEVEL     (1)
   ) dut_b (
      .control_clock (clk),
      .reset         (rst),
      .input_data    (in_b),
      .output_data   (out_b),
      .rise_pulse    (rise_b),
      .fall_pulse    (fall_b),
      .glitch_clear  (clr),
      .glitch_count  (gc_b)
   );

   // Reference model: a delay line per channel, then "held opposite value for D samples" rule.
   logic m_line[2][4][3];
   logic m_out[2][4];
   logic m_rise[2][4];
   logic m_fall[2][4];
   int   m_run[2][4];
   int   m_gl[2][4];

   function automatic int n_ch(input int d);  return d ? 4 : 2; endfunction
   function automatic int n_syn(input int d); return d ? 3 : 2; endfunction
   function automatic int n_deb(input int d); return d ? 1 : 8; endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic [1:0] a, input logic [3:0] b, input logic r, input logic c);
      for (int d = 0; d < 2; d++) begin
         for (int ch = 0; ch < n_ch(d); ch++) begin
            logic x, seen;
            bit   rejected;
            x        = d ? b[ch] : a[ch];
            seen     = m_line[d][ch][n_syn(d)-1];
            rejected = 1'b0;
            m_rise[d][ch] = 1'b0;
            m_fall[d][ch] = 1'b0;
            if (r) begin
               for (int s = 0; s < 3; s++) m_line[d][ch][s] = 1'b1;
               m_out[d][ch] = 1'b1;
               m_run[d][ch] = 0;
               m_gl[d][ch]  = 0;
            end else begin
               if (seen != m_out[d][ch]) begin
                  m_run[d][ch]++;
                  if (m_run[d][ch] == n_deb(d)) begin
                     m_out[d][ch]  = seen;
                     m_rise[d][ch] = seen;
                     m_fall[d][ch] = !seen;
                     m_run[d][ch]  = 0;
                  end
               end else begin
                  rejected     = (m_run[d][ch] != 0);
                  m_run[d][ch] = 0;
               end
               if (c) m_gl[d][ch] = 0;
               else if (GEN && rejected && m_gl[d][ch] < 255) m_gl[d][ch]++;
               for (int s = 2; s > 0; s--) m_line[d][ch][s] = m_line[d][ch][s-1];
               m_line[d][ch][0] = x;
            end
         end
      end
   endtask

   task automatic step(input logic [1:0] a, input logic [3:0] b, input logic r, input logic c);
      logic [1:0]  ea, ra, fa;
      logic [3:0]  eb, rb, fb;
      logic [15:0] ga;
      logic [31:0] gb;
      in_a = a; in_b = b; rst = r; clr = c;
      @(posedge clk);
      model_edge(a, b, r, c);
      #1;
      for (int ch = 0; ch < 2; ch++) begin
         ea[ch] = m_out[0][ch]; ra[ch] = m_rise[0][ch]; fa[ch] = m_fall[0][ch];
         ga[8*ch +: 8] = 8'(m_gl[0][ch]);
      end
      for (int ch = 0; ch < 4; ch++) begin
         eb[ch] = m_out[1][ch]; rb[ch] = m_rise[1][ch]; fb[ch] = m_fall[1][ch];
         gb[8*ch +: 8] = 8'(m_gl[1][ch]);
      end
      chk("out_a", 32'(out_a), 32'(ea));
      chk("rise_a", 32'(rise_a), 32'(ra));
      chk("fall_a", 32'(fall_a), 32'(fa));
      chk("glitch_a", 32'(gc_a), 32'(ga));
      chk("out_b", 32'(out_b), 32'(eb));
      chk("rise_b", 32'(rise_b), 32'(rb));
      chk("fall_b", 32'(fall_b), 32'(fb));
      chk("glitch_b", gc_b, gb);
   endtask

   initial begin
      logic [1:0] ra;
      logic [3:0] rb;
      int hold;
      in_a = 2'b11; in_b = 4'hF; rst = 1'b1; clr = 1'b0;

      // Reset and idle-high hold
      for (int i = 0; i < 3; i++) step(2'b11, 4'hF, 1'b1, 1'b0);
      for (int i = 0; i < 12; i++) step(2'b11, 4'hF, 1'b0, 1'b0);
      chk("idle_out", 32'(out_a), 32'h3);

      // Ch0 falls: output changes on the 10th edge after the change
      for (int i = 1; i <= 12; i++) begin
         step(2'b10, 4'hF, 1'b0, 1'b0);
         if (i == 9)  chk("ch0_fall_pre", 32'(out_a), 32'h3);
         if (i == 10) chk("ch0_fall_out", 32'(out_a), 32'h2);
         if (i == 10) chk("ch0_fall_pulse", 32'(fall_a), 32'h1);
         if (i == 11) chk("ch0_fall_once", 32'(fall_a), 32'h0);
      end

      // Ch1 low for 5 cycles: rejected
      for (int i = 0; i < 5; i++) step(2'b00, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step(2'b10, 4'hF, 1'b0, 1'b0);
      chk("ch1_short_out", 32'(out_a[1]), 32'h1);
      chk("ch1_glitch", 32'(gc_a[15:8]), GEN ? 32'd1 : 32'd0);
      for (int i = 0; i < 12; i++) step(2'b11, 4'hF, 1'b0, 1'b0);

      // 300 two-cycle glitches on ch0 saturate its counter
      for (int g = 0; g < 300; g++) begin
         step(2'b10, 4'hF, 1'b0, 1'b0);
         step(2'b10, 4'hF, 1'b0, 1'b0);
         step(2'b11, 4'hF, 1'b0, 1'b0);
         step(2'b11, 4'hF, 1'b0, 1'b0);
      end
      chk("ch0_sat", 32'(gc_a[7:0]), GEN ? 32'd255 : 32'd0);
      for (int k = 0; k < 6; k++) step((k < 2) ? 2'b10 : 2'b11, 4'hF, 1'b0, 1'b1);
      chk("clear_wins", 32'(gc_a[7:0]), 32'd0);
      step(2'b11, 4'hF, 1'b0, 1'b0);
      chk("clear_hold", 32'(gc_a[7:0]), 32'd0);
      for (int i = 0; i < 12; i++) step(2'b11, 4'hF, 1'b0, 1'b0);

      // Reset during a qualifying run
      for (int i = 0; i < 6; i++) step(2'b10, 4'hF, 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         step(2'b10, 4'hF, 1'b1, 1'b0);
         chk("rst_mid_out", 32'(out_a), 32'h3);
         chk("rst_mid_pulse", 32'({rise_a, fall_a}), 32'h0);
      end
      for (int i = 1; i <= 11; i++) begin
         step(2'b10, 4'hF, 1'b0, 1'b0);
         if (i == 9)  chk("rst_run_pre", 32'(out_a[0]), 32'h1);
         if (i == 10) chk("rst_run_out", 32'(out_a[0]), 32'h0);
         if (i == 10) chk("rst_run_pulse", 32'(fall_a[0]), 32'h1);
      end

      // D=1, S=3: toggle all four together
      for (int i = 1; i <= 5; i++) begin
         step(2'b10, 4'h0, 1'b0, 1'b0);
         if (i == 3) chk("b_fall_pre", 32'(out_b), 32'hF);
         if (i == 4) chk("b_fall_out", 32'(out_b), 32'h0);
         if (i == 4) chk("b_fall_pulse", 32'(fall_b), 32'hF);
         if (i == 5) chk("b_fall_once", 32'(fall_b), 32'h0);
      end
      for (int i = 1; i <= 5; i++) begin
         step(2'b10, 4'hF, 1'b0, 1'b0);
         if (i == 4) chk("b_rise_out", 32'(out_b), 32'hF);
         if (i == 4) chk("b_rise_pulse", 32'(rise_b), 32'hF);
      end

      // Randomised hold lengths, occasional clear and reset
      for (int n = 0; n < 120; n++) begin
         ra   = 2'($urandom);
         rb   = 4'($urandom);
         hold = $urandom_range(1, 12);
         for (int h = 0; h < hold; h++)
            step(ra, rb, ($urandom_range(0, 150) == 0), ($urandom_range(0, 20) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
